mem_traverse: RTL and testbench
===============================

MEM_TRAVERSE -- requirements
Module: mem_traverse

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, loop memory address width; depth = 2**ADDR_WIDTH.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 step  input  1  asynchronous-rate sample strobe (level); each rising edge advances traversal once.
REQ-005 write  input  1  record/overdub request (level).
REQ-006 read  input  1  playback request (level).
REQ-007 reverse  input  1  playback direction; 1 = descending.
REQ-008 curr_addr  output  ADDR_WIDTH  current memory address, registered.
REQ-009 loop_max  output  ADDR_WIDTH  highest address of recorded loop, registered.
REQ-010 loop_exists  output  1  at least one sample recorded, registered.
REQ-011 first_write_done  output  1  initial recording finished, registered.
REQ-012 full  output  1  initial recording wrapped past top address, registered.
REQ-013 cycle  output  1  one-clk pulse at each playback loop boundary, registered.

Function
REQ-014 Internal step pulse stp = one-clk pulse on each 0->1 transition of step (via signal_cutter); no other event advances curr_addr.
REQ-015 Effective mode per clk: wr = write & ~reverse; rd = read & ~wr & loop_exists; else idle; write with reverse high is ignored.
REQ-016 Initial record (wr, first_write_done=0) on stp: curr_addr +1, wrapping 2**ADDR_WIDTH-1 -> 0; loop_max = max(loop_max, curr_addr); loop_exists <= 1.
REQ-017 Initial-record wrap (curr_addr = 2**ADDR_WIDTH-1 on stp) SHALL set full <= 1 and loop_max <= 2**ADDR_WIDTH-1.
REQ-018 Overdub (wr, first_write_done=1) on stp: curr_addr +1, wrapping loop_max -> 0; loop_max unchanged.
REQ-019 Falling edge of wr (wr was 1 last clk, now 0) SHALL set first_write_done <= 1 and load curr_addr with 0 (reverse=0) or loop_max (reverse=1), regardless of stp.
REQ-020 Forward playback (rd, reverse=0) on stp: curr_addr +1; if curr_addr >= loop_max, load 0 and pulse cycle.
REQ-021 Reverse playback (rd, reverse=1) on stp: curr_addr -1; if curr_addr = 0, load loop_max and pulse cycle.
REQ-022 Direction change mid-playback SHALL continue from the current address, no jump.
REQ-023 Idle, or read with loop_exists=0: curr_addr holds, cycle=0.
REQ-024 cycle high exactly one clk, in the clk after the wrapping stp; 0 otherwise.
REQ-025 read and write both high: write wins (REQ-015).
REQ-026 loop_exists, first_write_done, full remain set until reset.

Reset
REQ-027 Reset SHALL clear curr_addr, loop_max, loop_exists, first_write_done, full, cycle to 0 and the signal_cutter history register to 0.
REQ-028 Reset overrides all inputs in the same clk; reset mid-record or mid-playback discards the loop.
REQ-029 If step is high on the first clk after reset, one stp is generated.

Structure
REQ-030 Sub-module signal_cutter (ports clk, reset, in, out): out = in & ~prev & ~reset, prev registered; one instance on step.
REQ-031 Shared package holds the mode enum (IDLE, REC, OVERDUB, PLAY) and default ADDR_WIDTH constant; no other typedefs.
REQ-032 No memory inside mem_traverse; the parent owns storage addressed by curr_addr.

Verification (ADDR_WIDTH=3, step toggles every 3 clk)
REQ-033 Reset 3 clk -> all outputs 0; step edges while idle -> curr_addr stays 0.
REQ-034 write=1 for 5 stp then write=0 -> curr_addr 0..5 seen, loop_max=4, loop_exists=1, first_write_done=1, curr_addr=0, full=0.
REQ-035 write=1 for 9 stp -> curr_addr wraps 7->0, full=1, loop_max=7.
REQ-036 After REQ-034 loop, read=1 forward 6 stp -> 1,2,3,4,0,1; cycle pulses once at 4->0.
REQ-037 Then reverse=1 -> 0,4,3,2,1,0,4; cycle pulses at each 0->4; overdub write=1 -> wraps 4->0, loop_max stays 4.
REQ-038 read=1 with loop_exists=0 -> curr_addr holds 0; write&reverse -> no advance; read&write -> record behaviour.

Source files
------------

// File: rtl/mem_traverse_pkg.sv
// Shared definitions for the loop-memory address traversal block.
package mem_traverse_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    OVERDUB,
    PLAY
  } mode_t;

endpackage

// File: rtl/mem_traverse_if.sv
// Control inputs and traversal status outputs of mem_traverse, bundled as one port.
interface mem_traverse_if #(
  parameter int ADDR_WIDTH = mem_traverse_pkg::DEFAULT_ADDR_WIDTH
);

  logic                  step;
  logic                  write;
  logic                  read;
  logic                  reverse;
  logic [ADDR_WIDTH-1:0] curr_addr;
  logic [ADDR_WIDTH-1:0] loop_max;
  logic                  loop_exists;
  logic                  first_write_done;
  logic                  full;
  logic                  cycle;

  modport master (
    output step, write, read, reverse,
    input  curr_addr, loop_max, loop_exists, first_write_done, full, cycle
  );

  modport slave (
    input  step, write, read, reverse,
    output curr_addr, loop_max, loop_exists, first_write_done, full, cycle
  );

endinterface

// File: rtl/mem_traverse_signal_cutter.sv
// Turns a level into a one-clk pulse on each 0->1 transition; suppressed while in reset.
module signal_cutter (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign out = in & ~prev & ~reset;

endmodule

// File: rtl/mem_traverse.sv
// Address sequencer for a looper memory owned by the parent: records, overdubs
// and plays back a loop, advancing one address per rising edge of step.
module mem_traverse
  import mem_traverse_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input logic           clk,
  input logic           reset,
  mem_traverse_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

  logic                  stp;
  logic                  wr;
  logic                  rd;
  logic                  wr_p1;
  logic                  wr_fall;
  mode_t                 mode;

  logic [ADDR_WIDTH-1:0] addr_q,   addr_nxt;
  logic [ADDR_WIDTH-1:0] max_q,    max_nxt;
  logic                  exists_q, exists_nxt;
  logic                  done_q,   done_nxt;
  logic                  full_q,   full_nxt;
  logic                  cycle_q,  cycle_nxt;

  signal_cutter u_step_cutter (
    .clk   (clk),
    .reset (reset),
    .in    (bus.step),
    .out   (stp)
  );

  // Write with reverse held is treated as no write at all; write beats read.
  assign wr      = bus.write & ~bus.reverse;
  assign rd      = bus.read & ~wr & exists_q;
  assign wr_fall = wr_p1 & ~wr;

  always_comb begin
    mode = IDLE;
    if (wr)      mode = done_q ? OVERDUB : REC;
    else if (rd) mode = PLAY;
  end

  always_comb begin
    addr_nxt   = addr_q;
    max_nxt    = max_q;
    exists_nxt = exists_q;
    done_nxt   = done_q;
    full_nxt   = full_q;
    cycle_nxt  = 1'b0;

    // End of a write pass re-aims the pointer at the loop start for the current direction.
    if (wr_fall) begin
      done_nxt = 1'b1;
      addr_nxt = bus.reverse ? max_q : '0;
    end else if (stp) begin
      case (mode)
        REC: begin
          exists_nxt = 1'b1;
          addr_nxt   = addr_q + 1'b1;
          if (addr_q == TOP_ADDR) begin
            full_nxt = 1'b1;
            max_nxt  = TOP_ADDR;
          end else if (addr_q > max_q) begin
            max_nxt  = addr_q;
          end
        end
        OVERDUB: begin
          addr_nxt = (addr_q >= max_q) ? '0 : addr_q + 1'b1;
        end
        PLAY: begin
          if (bus.reverse) begin
            if (addr_q == '0) begin
              addr_nxt  = max_q;
              cycle_nxt = 1'b1;
            end else begin
              addr_nxt  = addr_q - 1'b1;
            end
          end else begin
            if (addr_q >= max_q) begin
              addr_nxt  = '0;
              cycle_nxt = 1'b1;
            end else begin
              addr_nxt  = addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      max_q    <= '0;
      exists_q <= 1'b0;
      done_q   <= 1'b0;
      full_q   <= 1'b0;
      cycle_q  <= 1'b0;
      wr_p1    <= 1'b0;
    end else begin
      addr_q   <= addr_nxt;
      max_q    <= max_nxt;
      exists_q <= exists_nxt;
      done_q   <= done_nxt;
      full_q   <= full_nxt;
      cycle_q  <= cycle_nxt;
      wr_p1    <= wr;
    end
  end

  assign bus.curr_addr        = addr_q;
  assign bus.loop_max         = max_q;
  assign bus.loop_exists      = exists_q;
  assign bus.first_write_done = done_q;
  assign bus.full             = full_q;
  assign bus.cycle            = cycle_q;

endmodule

// File: tb/tb_mem_traverse.sv
// Scoreboard bench for mem_traverse with a small ADDR_WIDTH so wraps are reachable.
module tb_mem_traverse;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;

  mem_traverse_if #(.ADDR_WIDTH(AW)) bus ();

  mem_traverse #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  int         trace[$];
  int         cyc_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the spec's rules written with plain integers and modular arithmetic.
  int m_addr, m_max;
  bit m_exists, m_done, m_full, m_cyc, m_prev_step, m_prev_wr;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_addr = 0; m_max = 0; m_exists = 0; m_done = 0; m_full = 0; m_cyc = 0;
        m_prev_step = 0; m_prev_wr = 0;
      end else begin
        bit s, w, r;
        s = bus.step && !m_prev_step;
        w = bus.write && !bus.reverse;
        r = bus.read && !w && m_exists;
        m_cyc = 0;
        if (m_prev_wr && !w) begin
          m_done = 1;
          m_addr = bus.reverse ? m_max : 0;
        end else if (s && w && !m_done) begin
          if (m_addr == DEPTH - 1) begin
            m_full = 1;
            m_max  = DEPTH - 1;
          end else if (m_addr > m_max) begin
            m_max = m_addr;
          end
          m_addr   = (m_addr + 1) % DEPTH;
          m_exists = 1;
        end else if (s && w) begin
          m_addr = (m_addr >= m_max) ? 0 : m_addr + 1;
        end else if (s && r && !bus.reverse) begin
          if (m_addr >= m_max) begin m_addr = 0; m_cyc = 1; end
          else m_addr = m_addr + 1;
        end else if (s && r) begin
          if (m_addr == 0) begin m_addr = m_max; m_cyc = 1; end
          else m_addr = m_addr - 1;
        end
        m_prev_step = bus.step;
        m_prev_wr   = w;
      end
      exp_q.push_back({3'(m_addr), 3'(m_max), m_exists, m_done, m_full, m_cyc});
    end
  end

  // Monitor: compare every registered output once per clk against the model.
  initial begin
    forever begin
      logic [9:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{addr,max,exists,done,full,cycle}",
              {22'd0, bus.curr_addr, bus.loop_max, bus.loop_exists,
               bus.first_write_done, bus.full, bus.cycle},
              {22'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One step period = 3 clk high + 3 clk low; records curr_addr after each rising edge.
  task automatic do_steps(input int n);
    trace   = {};
    cyc_cnt = 0;
    for (int i = 0; i < n; i++) begin
      bus.step = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (k == 0) trace.push_back(int'(bus.curr_addr));
        if (bus.cycle) cyc_cnt++;
      end
      bus.step = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (bus.cycle) cyc_cnt++;
      end
    end
  endtask

  task automatic check_trace(input string name, input int exp[$]);
    check({name, "_len"}, trace.size(), exp.size());
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      check($sformatf("%s[%0d]", name, i), trace[i], exp[i]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.step = 0; bus.write = 0; bus.read = 0; bus.reverse = 0;
    reset = 1'b1;
    #2;
    do_reset(3);
    check("reset_addr", bus.curr_addr, 0);
    check("reset_flags", {bus.loop_max, bus.loop_exists, bus.first_write_done, bus.full, bus.cycle}, 0);

    do_steps(2);
    check_trace("idle_steps", '{0, 0});

    bus.write = 1;
    do_steps(5);
    check_trace("first_record", '{1, 2, 3, 4, 5});
    bus.write = 0;
    tick();
    check("rec_addr_after_fall", bus.curr_addr, 0);
    check("rec_loop_max", bus.loop_max, 4);
    check("rec_exists_done_full", {bus.loop_exists, bus.first_write_done, bus.full}, 3'b110);

    bus.read = 1;
    do_steps(6);
    check_trace("play_fwd", '{1, 2, 3, 4, 0, 1});
    check("play_fwd_cycles", cyc_cnt, 1);

    bus.reverse = 1;
    do_steps(7);
    check_trace("play_rev", '{0, 4, 3, 2, 1, 0, 4});
    check("play_rev_cycles", cyc_cnt, 2);

    bus.reverse = 0; bus.read = 0; bus.write = 1;
    do_steps(3);
    check_trace("overdub", '{0, 1, 2});
    check("overdub_loop_max", bus.loop_max, 4);
    bus.write = 0;
    tick();
    check("overdub_fall_addr", bus.curr_addr, 0);

    bus.write = 1; bus.read = 1;
    do_steps(2);
    check_trace("read_and_write", '{1, 2});
    bus.write = 0; bus.read = 0;
    tick();

    bus.write = 1; bus.reverse = 1;
    do_steps(2);
    check_trace("write_reverse_ignored", '{0, 0});
    bus.write = 0; bus.reverse = 0;
    tick();

    do_reset(2);
    bus.read = 1;
    do_steps(2);
    check_trace("read_no_loop", '{0, 0});
    bus.read = 0;

    bus.write = 1;
    do_steps(9);
    check_trace("record_wrap", '{1, 2, 3, 4, 5, 6, 7, 0, 1});
    check("wrap_full", bus.full, 1);
    check("wrap_loop_max", bus.loop_max, 7);
    bus.write = 0;
    tick();

    bus.step = 1; bus.write = 1;
    do_reset(3);
    tick();
    check("step_high_after_reset", bus.curr_addr, 1);
    bus.step = 0; bus.write = 0;
    tick();

    for (int i = 0; i < 900; i++) begin
      tick();
      if ($urandom_range(0, 2) == 0) bus.step = ~bus.step;
      if ($urandom_range(0, 29) == 0) bus.write = ~bus.write;
      if ($urandom_range(0, 19) == 0) bus.read = ~bus.read;
      if ($urandom_range(0, 39) == 0) bus.reverse = ~bus.reverse;
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
